// File: rtl/fpmul_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_pipe_if
// Brief   : Operand/result handshake bundle for the pipelined FP multiplier.
// Rev     : 1.0  initial release
// ============================================================================
interface fpmul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   a;
  logic [EXP_W+MAN_W:0]   b;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   c;
  logic                   ovf;
  logic                   unf;
  logic                   inv;
  logic                   over_mul_under;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, ovf, unf, inv, over_mul_under
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, ovf, unf, inv, over_mul_under
  );
endinterface
`default_nettype wire

// File: rtl/fpmul_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_pipe
// Brief   : Parametrised pipelined IEEE-style multiplier, RNE rounding, FTZ.
// Rev     : 1.0  initial release
// ============================================================================
module fpmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  fpmul_pipe_if.slave  bus
);

  localparam int c_W     = 1 + EXP_W + MAN_W;
  localparam int c_PW    = 2 * (MAN_W + 1);
  localparam int c_NPOST = (STAGES >= 2) ? STAGES - 1 : 1;

  localparam logic [EXP_W+1:0] c_BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] c_EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [c_W-1:0]   c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [1:0] c_CLS_NORM = 2'd0;
  localparam logic [1:0] c_CLS_NAN  = 2'd1;
  localparam logic [1:0] c_CLS_INF  = 2'd2;
  localparam logic [1:0] c_CLS_ZERO = 2'd3;

  typedef struct packed {
    logic             s;
    logic [1:0]       cls;
    logic [EXP_W+1:0] e;
    logic [c_PW-1:0]  p;
  } mid_t;

  typedef struct packed {
    logic [c_W-1:0] c;
    logic           ovf;
    logic           unf;
    logic           inv;
    logic           omu;
  } res_t;

  logic                 w_stall;
  logic                 w_sa, w_sb;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [MAN_W-1:0]     w_fa, w_fb;
  logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  mid_t                 w_front;
  mid_t                 w_mid;
  logic                 w_mid_v;

  logic                 w_msb;
  logic [c_PW-2:0]      w_pn;
  logic                 w_guard, w_sticky, w_rup;
  logic [MAN_W:0]       w_fr;
  logic [EXP_W+1:0]     w_en, w_ef;
  logic                 w_unf, w_ovf;
  res_t                 w_res;

  logic [c_NPOST-1:0]   r_pv;
  res_t                 r_pres [c_NPOST];

  assign w_stall      = r_pv[c_NPOST-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  assign {w_sa, w_ea, w_fa} = bus.a;
  assign {w_sb, w_eb, w_fb} = bus.b;

  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  // Decode and raw significand product; denormals count as zero.
  always_comb begin
    w_front.s = w_sa ^ w_sb;
    w_front.e = {2'b00, w_ea} + {2'b00, w_eb} - c_BIAS;
    w_front.p = {{(MAN_W+1){1'b0}}, 1'b1, w_fa} * {{(MAN_W+1){1'b0}}, 1'b1, w_fb};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_front.cls = c_CLS_NAN;
    else if (w_a_inf || w_b_inf)
      w_front.cls = c_CLS_INF;
    else if (w_a_zero || w_b_zero)
      w_front.cls = c_CLS_ZERO;
    else
      w_front.cls = c_CLS_NORM;
  end

  generate
    if (STAGES >= 2) begin : g_split
      mid_t r_mid;
      logic r_mid_v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mid   <= '0;
          r_mid_v <= 1'b0;
        end else if (!w_stall) begin
          r_mid   <= w_front;
          r_mid_v <= bus.in_valid;
        end
      end
      assign w_mid   = r_mid;
      assign w_mid_v = r_mid_v;
    end else begin : g_flat
      assign w_mid   = w_front;
      assign w_mid_v = bus.in_valid;
    end
  endgenerate

  // Normalise, round to nearest even, then classify the final exponent.
  always_comb begin
    w_msb    = w_mid.p[c_PW-1];
    w_pn     = w_msb ? w_mid.p[c_PW-2:0] : {w_mid.p[c_PW-3:0], 1'b0};
    w_guard  = w_pn[MAN_W];
    w_sticky = |w_pn[MAN_W-1:0];
    w_rup    = w_guard & (w_sticky | w_pn[MAN_W+1]);
    w_fr     = {1'b0, w_pn[c_PW-2:MAN_W+1]} + {{MAN_W{1'b0}}, w_rup};
    w_en     = w_mid.e + {{(EXP_W+1){1'b0}}, w_msb};
    w_ef     = w_en + {{(EXP_W+1){1'b0}}, w_fr[MAN_W]};
    w_unf    = w_en[EXP_W+1] | (w_en == '0);
    w_ovf    = ~w_ef[EXP_W+1] & (w_ef >= c_EMAX);

    w_res = '0;
    case (w_mid.cls)
      c_CLS_NAN: begin
        w_res.c   = c_QNAN;
        w_res.inv = 1'b1;
      end
      c_CLS_INF:  w_res.c = {w_mid.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c_CLS_ZERO: w_res.c = {w_mid.s, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (w_unf) begin
          w_res.c   = {w_mid.s, {(EXP_W+MAN_W){1'b0}}};
          w_res.unf = 1'b1;
          w_res.omu = 1'b1;
        end else if (w_ovf) begin
          w_res.c   = {w_mid.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_res.ovf = 1'b1;
          w_res.omu = 1'b1;
        end else begin
          w_res.c   = {w_mid.s, w_ef[EXP_W-1:0], w_fr[MAN_W-1:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int i = 0; i < c_NPOST; i++) r_pres[i] <= '0;
    end else if (!w_stall) begin
      r_pv[0]   <= w_mid_v;
      r_pres[0] <= w_res;
      for (int i = 1; i < c_NPOST; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pres[i] <= r_pres[i-1];
      end
    end
  end

  assign bus.out_valid      = r_pv[c_NPOST-1];
  assign bus.c              = r_pres[c_NPOST-1].c;
  assign bus.ovf            = r_pres[c_NPOST-1].ovf;
  assign bus.unf            = r_pres[c_NPOST-1].unf;
  assign bus.inv            = r_pres[c_NPOST-1].inv;
  assign bus.over_mul_under = r_pres[c_NPOST-1].omu;

endmodule
`default_nettype wire
